vector_fork_sequencer: RTL and testbench
========================================

// Module: vector_fork_sequencer
// PURPOSE
//  Parametrised successor to the vector fork stage. Captures two V-element register-file
//  read vectors plus a scalar, then streams them to the LANES-wide vector ALU as
//  ceil(V/LANES) chunk pairs (A,B) over a valid/ready handshake.
//  Supports vector-vector and vector-scalar ops, ragged last chunks via lane mask, and backpressure.
// PARAMETERS
//  N      32  element width in bits
//  V      20  elements per vector register, >=1
//  LANES  4   ALU lanes per chunk, 1..V
//  (derived) NCHUNK = ceil(V/LANES); CW = max(1,$clog2(NCHUNK))
// PORTS
//  CLK         in   1            system clock, all state updates on rising edge
//  RST         in   1            synchronous reset, active-high
//  Start_i     in   1            request to fork a new operand pair
//  OpType_i    in   2            01 vector-vector, 10 vector-scalar, 11 scalar-vector (macro), 00 illegal
//  RD1_VEC_i   in   [V][N]       source vector 1, sampled only on accepted start
//  RD2_VEC_i   in   [V][N]       source vector 2, sampled only on accepted start
//  Scalar_i    in   N            scalar operand, sampled only on accepted start
//  Ready_i     in   1            ALU accepts current chunk
//  Valid_o     out  1            current chunk valid
//  Vec_A_o     out  [LANES][N]   chunk of operand A
//  Vec_B_o     out  [LANES][N]   chunk of operand B
//  LaneMask_o  out  LANES        bit l = lane l holds a real element
//  ChunkIdx_o  out  CW           index of current chunk
//  Last_o      out  1            current chunk is NCHUNK-1
//  Busy_o      out  1            state != IDLE
//  Done_o      out  1            one-cycle pulse after last chunk handshake
//  Err_o       out  1            one-cycle pulse on illegal start
// BEHAVIOUR
//  - Synchronous RST: state=IDLE; every output 0; operand regs cleared. RST mid-op aborts, no Done_o.
//  - All outputs registered. FSM states: IDLE, RUN.
//  - IDLE: Start_i & legal OpType_i -> latch RD1/RD2/Scalar/OpType, ChunkIdx=0, go RUN;
//    Valid_o=1 from the next cycle (1-cycle start-to-valid latency).
//  - IDLE: Start_i & illegal OpType_i -> Err_o=1 for one cycle, stay IDLE, nothing latched.
//  - RUN: chunk k, lane l maps to element e=k*LANES+l.
//    A[l]=RD1[e] (01,10), B[l]=RD2[e] (01) or Scalar (10).
//  - Lanes with e>=V: A=B=0, LaneMask bit 0. Full chunks: mask all ones.
//  - Valid_o&Ready_i: ChunkIdx++ next cycle; outputs stable while Valid_o&!Ready_i.
//  - Handshake on Last_o chunk: next cycle Valid_o=0, Done_o=1 (one cycle), state=IDLE.
//  - Back-to-back: Start_i is accepted in the Done_o cycle (IDLE), giving a one-bubble gap.
//  - Start_i while RUN ignored (no Err_o); input vectors may change freely after latch.
//  - NCHUNK=1: single chunk, Last_o=1 with first Valid_o.
//  - ChunkIdx never wraps; it is cleared on start.
// CONFIGURATION
//  FORK_SCALAR_SWAP_EN defined: OpType 11 legal.
//    A[l]=Scalar, B[l]=RD2[e] (scalar-vector, for non-commutative ops). Padding rules unchanged.
//  Not defined: OpType 11 is illegal (Err_o pulse, no latch), same as 00.
// TESTING
//  1 V=20,LANES=4,OpType=01,RD1[i]=i,RD2[i]=2i,Ready=1 -> 5 chunks; chunk0 A={3,2,1,0},B={6,4,2,0};
//    Last_o on chunk4 A={19..16}; Done_o pulse next cycle.
//  2 OpType=10,Scalar=3 -> every chunk B={3,3,3,3}; A as test 1.
//  3 Ready_i low 3 cycles on chunk2 -> Valid_o held, A={11,10,9,8} stable; total 8 valid cycles.
//  4 V=10,LANES=4,OpType=01 -> 3 chunks; chunk2 LaneMask=4'b0011, A={0,0,9,8}, B={0,0,18,16}.
//  5 RST at chunk2, then Start again -> all outputs 0 after reset edge, no Done_o; new op restarts at chunk0.
//  6 OpType=00 -> Err_o pulse, Busy_o stays 0.
//    OpType=11 with FORK_SCALAR_SWAP_EN -> A={3,3,3,3},B={6,4,2,0}; without it -> Err_o pulse.

Source files
------------

// File: rtl/vector_fork_sequencer_if.sv
// Operand-capture and chunk-stream signals of the vector fork sequencer.
// The sequencer itself uses the slave modport; the requester/ALU side uses master.
interface vector_fork_sequencer_if #(
   parameter int N     = 32,
   parameter int V     = 20,
   parameter int LANES = 4
);
   localparam int NCHUNK = (V + LANES - 1) / LANES;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   logic                      start;
   logic [1:0]                op_type;
   logic [V-1:0][N-1:0]       rd1_vec;
   logic [V-1:0][N-1:0]       rd2_vec;
   logic [N-1:0]              scalar;
   logic                      ready;
   logic                      valid;
   logic [LANES-1:0][N-1:0]   vec_a;
   logic [LANES-1:0][N-1:0]   vec_b;
   logic [LANES-1:0]          lane_mask;
   logic [CW-1:0]             chunk_idx;
   logic                      last;
   logic                      busy;
   logic                      done;
   logic                      err;

   modport master (
      output start, op_type, rd1_vec, rd2_vec, scalar, ready,
      input  valid, vec_a, vec_b, lane_mask, chunk_idx, last, busy, done, err
   );

   modport slave (
      input  start, op_type, rd1_vec, rd2_vec, scalar, ready,
      output valid, vec_a, vec_b, lane_mask, chunk_idx, last, busy, done, err
   );
endinterface

// File: rtl/vector_fork_sequencer.sv
// Latches two V-element vectors plus a scalar and streams them as LANES-wide chunk pairs.
// Optional macro FORK_SCALAR_SWAP_EN makes op type 11 (scalar-vector) legal.
module vector_fork_sequencer #(
   parameter int N     = 32,
   parameter int V     = 20,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   vector_fork_sequencer_if.slave bus
);
   localparam int NCHUNK = (V + LANES - 1) / LANES;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int EW     = (V > 1) ? $clog2(V) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             idx_q, idx_d;
   logic [1:0]                op_q, op_d;
   logic [V-1:0][N-1:0]       rd1_q, rd1_d;
   logic [V-1:0][N-1:0]       rd2_q, rd2_d;
   logic [N-1:0]              scalar_q, scalar_d;

   logic                      valid_q, valid_d;
   logic [LANES-1:0][N-1:0]   a_q, a_d;
   logic [LANES-1:0][N-1:0]   b_q, b_d;
   logic [LANES-1:0]          mask_q, mask_d;
   logic [CW-1:0]             cidx_q, cidx_d;
   logic                      last_q, last_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   function automatic logic op_legal(input logic [1:0] op);
`ifdef FORK_SCALAR_SWAP_EN
      return op != 2'b00;
`else
      return (op == 2'b01) || (op == 2'b10);
`endif
   endfunction

   always_comb begin
      int            e;
      logic [EW-1:0] ei;
      state_d  = state_q;
      idx_d    = idx_q;
      op_d     = op_q;
      rd1_d    = rd1_q;
      rd2_d    = rd2_q;
      scalar_d = scalar_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      e        = 0;
      ei       = '0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (op_legal(bus.op_type)) begin
                  op_d     = bus.op_type;
                  rd1_d    = bus.rd1_vec;
                  rd2_d    = bus.rd2_vec;
                  scalar_d = bus.scalar;
                  idx_d    = '0;
                  state_d  = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (valid_q && bus.ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Output stage: build the chunk that will be presented after this edge
      valid_d = (state_d == RUN);
      busy_d  = (state_d != IDLE);
      cidx_d  = valid_d ? idx_d : '0;
      last_d  = valid_d && (idx_d == LAST_IDX);
      a_d     = '0;
      b_d     = '0;
      mask_d  = '0;
      if (valid_d) begin
         for (int l = 0; l < LANES; l++) begin
            e = int'(idx_d) * LANES + l;
            if (e < V) begin
               ei        = EW'(e);
               mask_d[l] = 1'b1;
               case (op_d)
                  2'b01: begin
                     a_d[l] = rd1_d[ei];
                     b_d[l] = rd2_d[ei];
                  end
                  2'b10: begin
                     a_d[l] = rd1_d[ei];
                     b_d[l] = scalar_d;
                  end
                  2'b11: begin
                     a_d[l] = scalar_d;
                     b_d[l] = rd2_d[ei];
                  end
                  default: begin
                     a_d[l] = '0;
                     b_d[l] = '0;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         op_q     <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         scalar_q <= '0;
         valid_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         mask_q   <= '0;
         cidx_q   <= '0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         op_q     <= op_d;
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
         scalar_q <= scalar_d;
         valid_q  <= valid_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mask_q   <= mask_d;
         cidx_q   <= cidx_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.valid     = valid_q;
   assign bus.vec_a     = a_q;
   assign bus.vec_b     = b_q;
   assign bus.lane_mask = mask_q;
   assign bus.chunk_idx = cidx_q;
   assign bus.last      = last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_vector_fork_sequencer.sv
// Directed bench: a V=20/LANES=4 sequencer and a V=10/LANES=4 sequencer (ragged last chunk).
module tb_vector_fork_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   vector_fork_sequencer_if #(.N(32), .V(20), .LANES(4)) bus_a ();
   vector_fork_sequencer_if #(.N(32), .V(10), .LANES(4)) bus_b ();

   vector_fork_sequencer #(.N(32), .V(20), .LANES(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   vector_fork_sequencer #(.N(32), .V(10), .LANES(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] pack4(input int a3, input int a2, input int a1, input int a0);
      return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int nvalid;
   int stall;
   bit seen_done;

   initial begin
      bus_a.start = 1'b0; bus_a.op_type = 2'b00; bus_a.scalar = '0; bus_a.ready = 1'b1;
      bus_b.start = 1'b0; bus_b.op_type = 2'b00; bus_b.scalar = '0; bus_b.ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus_a.rd1_vec[i] = 32'(i);
         bus_a.rd2_vec[i] = 32'(2 * i);
      end
      for (int i = 0; i < 10; i++) begin
         bus_b.rd1_vec[i] = 32'(i);
         bus_b.rd2_vec[i] = 32'(2 * i);
      end

      // Reset state
      step(); step();
      rst = 1'b0;
      check_val("rst_valid", 128'(bus_a.valid), 128'd0);
      check_val("rst_busy",  128'(bus_a.busy),  128'd0);
      check_val("rst_done",  128'(bus_a.done),  128'd0);
      check_val("rst_err",   128'(bus_a.err),   128'd0);
      check_val("rst_veca",  bus_a.vec_a,       128'd0);

      // Vector-vector over 5 chunks
      bus_a.op_type = 2'b01; bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check_val($sformatf("vv_valid%0d", k), 128'(bus_a.valid), 128'd1);
         check_val($sformatf("vv_idx%0d", k), 128'(bus_a.chunk_idx), 128'(k));
         check_val($sformatf("vv_a%0d", k), bus_a.vec_a, pack4(4*k+3, 4*k+2, 4*k+1, 4*k));
         check_val($sformatf("vv_b%0d", k), bus_a.vec_b, pack4(8*k+6, 8*k+4, 8*k+2, 8*k));
         check_val($sformatf("vv_mask%0d", k), 128'(bus_a.lane_mask), 128'hF);
         check_val($sformatf("vv_last%0d", k), 128'(bus_a.last), 128'(k == 4));
         step();
      end
      check_val("vv_done", 128'(bus_a.done), 128'd1);
      check_val("vv_bubble", 128'(bus_a.valid), 128'd0);
      check_val("vv_busy_end", 128'(bus_a.busy), 128'd0);

      // Vector-scalar, started back-to-back in the done cycle
      bus_a.op_type = 2'b10; bus_a.scalar = 32'd3; bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      check_val("vs_done_clear", 128'(bus_a.done), 128'd0);
      for (int k = 0; k < 5; k++) begin
         check_val($sformatf("vs_a%0d", k), bus_a.vec_a, pack4(4*k+3, 4*k+2, 4*k+1, 4*k));
         check_val($sformatf("vs_b%0d", k), bus_a.vec_b, pack4(3, 3, 3, 3));
         step();
      end
      check_val("vs_done", 128'(bus_a.done), 128'd1);

      // Backpressure on chunk 2 for 3 cycles
      step();
      bus_a.op_type = 2'b01; bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      nvalid = 0; stall = 0; seen_done = 1'b0;
      for (int c = 0; c < 30 && !seen_done; c++) begin
         if (bus_a.done) seen_done = 1'b1;
         if (bus_a.valid) nvalid++;
         if (bus_a.valid && bus_a.chunk_idx == 2) begin
            check_val($sformatf("bp_hold_a%0d", stall), bus_a.vec_a, pack4(11, 10, 9, 8));
            if (stall < 3) begin
               bus_a.ready = 1'b0;
               stall++;
            end else begin
               bus_a.ready = 1'b1;
            end
         end else begin
            bus_a.ready = 1'b1;
         end
         if (!seen_done) step();
      end
      check_val("bp_done_seen", 128'(seen_done), 128'd1);
      check_val("bp_valid_cycles", 128'(nvalid), 128'd8);
      bus_a.ready = 1'b1;

      // Ragged last chunk on the V=10 instance
      bus_b.op_type = 2'b01; bus_b.start = 1'b1;
      step();
      bus_b.start = 1'b0;
      step(); step();
      check_val("rag_idx", 128'(bus_b.chunk_idx), 128'd2);
      check_val("rag_mask", 128'(bus_b.lane_mask), 128'h3);
      check_val("rag_a", bus_b.vec_a, pack4(0, 0, 9, 8));
      check_val("rag_b", bus_b.vec_b, pack4(0, 0, 18, 16));
      check_val("rag_last", 128'(bus_b.last), 128'd1);
      step();
      check_val("rag_done", 128'(bus_b.done), 128'd1);

      // Reset in the middle of an operation, then restart
      step();
      bus_a.op_type = 2'b01; bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      step(); step();
      check_val("mid_idx", 128'(bus_a.chunk_idx), 128'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("mid_rst_valid", 128'(bus_a.valid), 128'd0);
      check_val("mid_rst_busy",  128'(bus_a.busy),  128'd0);
      check_val("mid_rst_veca",  bus_a.vec_a,       128'd0);
      check_val("mid_rst_idx",   128'(bus_a.chunk_idx), 128'd0);
      step();
      check_val("mid_no_done", 128'(bus_a.done), 128'd0);
      bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      check_val("restart_idx", 128'(bus_a.chunk_idx), 128'd0);
      check_val("restart_a", bus_a.vec_a, pack4(3, 2, 1, 0));
      for (int k = 0; k < 5; k++) step();
      check_val("restart_done", 128'(bus_a.done), 128'd1);

      // Illegal op type 00
      step();
      bus_a.op_type = 2'b00; bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      check_val("op00_err", 128'(bus_a.err), 128'd1);
      check_val("op00_busy", 128'(bus_a.busy), 128'd0);
      step();
      check_val("op00_err_pulse", 128'(bus_a.err), 128'd0);

      // Op type 11: scalar-vector when enabled, illegal otherwise
      bus_a.op_type = 2'b11; bus_a.scalar = 32'd3; bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
`ifdef FORK_SCALAR_SWAP_EN
      check_val("op11_err", 128'(bus_a.err), 128'd0);
      check_val("op11_a", bus_a.vec_a, pack4(3, 3, 3, 3));
      check_val("op11_b", bus_a.vec_b, pack4(6, 4, 2, 0));
      for (int k = 0; k < 5; k++) step();
      check_val("op11_done", 128'(bus_a.done), 128'd1);
`else
      check_val("op11_err", 128'(bus_a.err), 128'd1);
      check_val("op11_busy", 128'(bus_a.busy), 128'd0);
      check_val("op11_valid", 128'(bus_a.valid), 128'd0);
`endif
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
